hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. It tracks every in-flight instruction from EX to the last pipeline stage in an internal scoreboard shift register. Each cycle it produces the EX-stage operand-forwarding selects, the load-use stall, and the branch flush. It replaces the hand-wired forwarding muxes and un-gated pipeline-register clears of the fixed 5-stage datapath, and supports configurable pipeline depth and load latency.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/fwd_pick.sv | 15 +
 rtl/hazard_fwd_unit.sv | 67 ++++++
 tb/tb_hazard_fwd_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard entry type, forward-select constants and helpers
package pipe_pkg;
  localparam int RA_MAX = 8;
  localparam int FWD_REG = 0;
  typedef struct packed {
    logic              v;
    logic [RA_MAX-1:0] rd;
    logic              we;
    logic              ld;
    logic [RA_MAX-1:0] rs1;
    logic [RA_MAX-1:0] rs2;
    logic              u1;
    logic              u2;
  } sb_entry_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic hits(input sb_entry_t e, input logic [RA_MAX-1:0] s, input logic used);
    return e.v && e.we && (e.rd != '0) && (e.rd == s) && used;
  endfunction
endpackage

// File: rtl/fwd_pick.sv
// fwd_pick: priority encoder from stage-match vector to forward select, youngest stage wins
module fwd_pick
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = clog2(DEPTH)
) (
  input  logic [DEPTH-1:1] hit,
  output logic [SEL_W-1:0] sel
);
  always_comb begin
    sel = SEL_W'(FWD_REG);
    for (int i = DEPTH - 1; i >= 1; i--) sel = hit[i] ? SEL_W'(i) : sel;
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-based EX operand forwarding, load-use stall and branch flush
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int RA_W       = 5,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);
  sb_entry_t [DEPTH:1] sb_q, sb_d;
  sb_entry_t           id_e;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [RA_MAX-1:0]   rs1_x, rs2_x;
  logic [DEPTH-1:1]    hit_a, hit_b;
  logic                lu;
  assign rs1_x = RA_MAX'(id_rs1);
  assign rs2_x = RA_MAX'(id_rs2);
  always_comb begin
    lu = 1'b0;
    for (int j = 1; j <= LOAD_STAGE - 2; j++)
      lu = lu | (sb_q[j].ld && (hits(sb_q[j], rs1_x, id_rs1_used) || hits(sb_q[j], rs2_x, id_rs2_used)));
    flush = ex_br_taken;
    stall = !rst && id_valid && !ex_br_taken && lu;
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k < DEPTH; k++) begin
      hit_a[k] = !rst && sb_q[1].v && hits(sb_q[k+1], sb_q[1].rs1, sb_q[1].u1);
      hit_b[k] = !rst && sb_q[1].v && hits(sb_q[k+1], sb_q[1].rs2, sb_q[1].u2);
    end
    id_e = '{v: 1'b1, rd: RA_MAX'(id_rd), we: id_rd_we, ld: id_is_load,
             rs1: rs1_x, rs2: rs2_x, u1: id_rs1_used, u2: id_rs2_used};
    sb_d = '0;
    sb_d[1] = (id_valid && !stall && !flush) ? id_e : '0;
    for (int k = 2; k <= DEPTH; k++) sb_d[k] = sb_q[k-1];
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  fwd_pick #(.DEPTH(DEPTH)) u_pick_a (.hit(hit_a), .sel(fwd_a));
  fwd_pick #(.DEPTH(DEPTH)) u_pick_b (.hit(hit_b), .sel(fwd_b));
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks on default, deep (5/4, 4-bit counter) and shallow (2/2) configurations
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, ex_br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic d_stall, d_flush, e_stall, e_flush, f_stall, f_flush;
  logic [1:0] d_fwd_a, d_fwd_b;
  logic [2:0] e_fwd_a, e_fwd_b;
  logic [0:0] f_fwd_a, f_fwd_b;
  logic [31:0] d_cnt, f_cnt;
  logic [3:0] e_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  hazard_fwd_unit u_d (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(d_stall), .flush(d_flush),
    .fwd_a(d_fwd_a), .fwd_b(d_fwd_b), .stall_cnt(d_cnt));
  hazard_fwd_unit #(.DEPTH(5), .LOAD_STAGE(4), .CNT_W(4)) u_e (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(e_stall), .flush(e_flush),
    .fwd_a(e_fwd_a), .fwd_b(e_fwd_b), .stall_cnt(e_cnt));
  hazard_fwd_unit #(.DEPTH(2), .LOAD_STAGE(2)) u_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(f_stall), .flush(f_flush),
    .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .stall_cnt(f_cnt));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; ex_br_taken = 0;
  endtask
  task automatic put(input logic [4:0] rd, input logic we, input logic ld,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_valid = 1; id_rd = rd; id_rd_we = we; id_is_load = ld;
    id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
  endtask
  task automatic drain();
    idle();
    repeat (5) tick();
  endtask
  initial begin
    idle();
    tick();
    tick();
    chk("rst_stall", 32'(d_stall), 0);
    chk("rst_flush", 32'(d_flush), 0);
    chk("rst_fwd_a", 32'(d_fwd_a), 0);
    chk("rst_fwd_b", 32'(d_fwd_b), 0);
    chk("rst_cnt", d_cnt, 0);
    chk("rst_e_cnt", 32'(e_cnt), 0);
    rst = 0;
    tick();
    // back-to-back ALU RAW on x5
    put(5, 1, 0, 1, 1, 2, 1); #1;
    chk("alu_nostall", 32'(d_stall), 0);
    tick();
    put(6, 1, 0, 5, 1, 1, 1);
    tick();
    put(9, 1, 0, 1, 1, 5, 1); #1;
    chk("alu_fwd_a1", 32'(d_fwd_a), 1);
    chk("alu_fwd_b0", 32'(d_fwd_b), 0);
    chk("alu_e_fwd_a1", 32'(e_fwd_a), 1);
    tick();
    idle(); #1;
    chk("alu_fwd_a0", 32'(d_fwd_a), 0);
    chk("alu_fwd_b2", 32'(d_fwd_b), 2);
    chk("alu_e_fwd_b2", 32'(e_fwd_b), 2);
    drain();
    // load-use: lw x7 ; add x8,x7,x7
    put(7, 1, 1, 2, 1, 0, 0); #1;
    chk("lu_pre_stall", 32'(d_stall), 0);
    tick();
    put(8, 1, 0, 7, 1, 7, 1); #1;
    chk("lu_stall", 32'(d_stall), 1);
    chk("lu_e_stall", 32'(e_stall), 1);
    chk("lu_f_nostall", 32'(f_stall), 0);
    chk("lu_flush", 32'(d_flush), 0);
    tick();
    chk("lu_cnt1", d_cnt, 1);
    chk("lu_e_cnt1", 32'(e_cnt), 1);
    chk("lu_stall_end", 32'(d_stall), 0);
    chk("lu_e_stall2", 32'(e_stall), 1);
    tick();
    chk("lu_fwd_a2", 32'(d_fwd_a), 2);
    chk("lu_fwd_b2", 32'(d_fwd_b), 2);
    chk("lu_e_stall_end", 32'(e_stall), 0);
    chk("lu_e_cnt2", 32'(e_cnt), 2);
    chk("lu_cnt_hold", d_cnt, 1);
    tick();
    idle(); #1;
    chk("lu_e_fwd_a3", 32'(e_fwd_a), 3);
    chk("lu_e_fwd_b3", 32'(e_fwd_b), 3);
    drain();
    // x0 destination and unused sources
    put(0, 1, 1, 0, 0, 0, 0);
    tick();
    put(1, 1, 0, 0, 1, 0, 1); #1;
    chk("x0_nostall", 32'(d_stall), 0);
    tick();
    idle(); #1;
    chk("x0_fwd_a", 32'(d_fwd_a), 0);
    chk("x0_fwd_b", 32'(d_fwd_b), 0);
    tick();
    put(7, 1, 1, 2, 1, 0, 0);
    tick();
    put(9, 1, 0, 7, 0, 0, 0); #1;
    chk("lui_nostall", 32'(d_stall), 0);
    chk("lui_e_nostall", 32'(e_stall), 0);
    tick();
    idle(); #1;
    chk("lui_fwd_a", 32'(d_fwd_a), 0);
    drain();
    // taken branch beats load-use
    put(7, 1, 1, 2, 1, 0, 0);
    tick();
    put(8, 1, 0, 7, 1, 7, 1);
    ex_br_taken = 1; #1;
    chk("br_flush", 32'(d_flush), 1);
    chk("br_stall", 32'(d_stall), 0);
    chk("br_e_stall", 32'(e_stall), 0);
    tick();
    ex_br_taken = 0;
    put(11, 1, 0, 8, 1, 0, 0); #1;
    chk("br_flush_off", 32'(d_flush), 0);
    chk("br_cnt", d_cnt, 1);
    chk("br_e_cnt", 32'(e_cnt), 2);
    tick();
    idle(); #1;
    chk("br_bubble_fwd", 32'(d_fwd_a), 0);
    drain();
    // youngest writer of x3 wins
    put(3, 1, 0, 1, 1, 1, 1);
    tick();
    put(3, 1, 0, 2, 1, 2, 1);
    tick();
    put(12, 1, 0, 3, 1, 3, 1);
    tick();
    idle(); #1;
    chk("young_fwd_a", 32'(d_fwd_a), 1);
    chk("young_fwd_b", 32'(d_fwd_b), 1);
    chk("young_e_fwd_a", 32'(e_fwd_a), 1);
    tick();
    chk("bubble_fwd_a", 32'(d_fwd_a), 0);
    drain();
    // reset with a pending load-use hazard
    put(7, 1, 1, 2, 1, 0, 0);
    tick();
    put(8, 1, 0, 7, 1, 7, 1); #1;
    chk("mid_pre_stall", 32'(d_stall), 1);
    rst = 1;
    tick();
    rst = 0; #1;
    chk("mid_stall", 32'(d_stall), 0);
    chk("mid_e_stall", 32'(e_stall), 0);
    chk("mid_cnt", d_cnt, 0);
    chk("mid_e_cnt", 32'(e_cnt), 0);
    chk("mid_fwd_a", 32'(d_fwd_a), 0);
    drain();
    // counter saturation on the 4-bit deep instance
    for (int p = 1; p <= 9; p++) begin
      put(7, 1, 1, 2, 1, 0, 0);
      tick();
      put(8, 1, 0, 7, 1, 7, 1);
      repeat (3) tick();
      chk("sat_e_cnt", 32'(e_cnt), (2 * p > 15) ? 15 : 2 * p);
      chk("sat_d_cnt", d_cnt, 32'(p));
    end
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
